// File: rtl/flash_cmd_responder_if.sv
// flash_cmd_responder_if: command byte stream from the controller plus the read-back/status return path.
interface flash_cmd_responder_if;
    logic [7:0] IO;
    logic       IOValid;
    logic [7:0] RdData;
    logic       RdValid;
    logic       Busy;
    logic       Error;
    modport master (output IO, IOValid, input RdData, RdValid, Busy, Error);
    modport slave (input IO, IOValid, output RdData, RdValid, Busy, Error);
endinterface

// File: rtl/flash_cmd_responder.sv
// flash_cmd_responder: decodes AA,55,<cmd> sequences, runs program/read/erase on a byte array, models busy time.
module flash_cmd_responder #(
    parameter int ADDR_W    = 4,
    parameter int PROG_CYC  = 4,
    parameter int ERASE_CYC = 8,
    parameter int CHIP_CYC  = 16
) (
    input logic SCL,
    input logic Reset,
    flash_cmd_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MAX_CYC = (PROG_CYC > ERASE_CYC) ? ((PROG_CYC > CHIP_CYC) ? PROG_CYC : CHIP_CYC)
                                                    : ((ERASE_CYC > CHIP_CYC) ? ERASE_CYC : CHIP_CYC);
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, UNLK, CMD, PADDR, PDATA, RADDR, EADDR, BUSY} stateT;

    stateT               state, stateNext;
    logic [CNT_W-1:0]    cnt, cntNext;
    logic [ADDR_W-1:0]   addr, addrNext, ioAddr, wrAddr;
    logic [7:0]          mem [DEPTH];
    logic [7:0]          wrData, rdData;
    logic                wrEn, chipErase, rdNext, errNext, rdValid, error;

    assign ioAddr = bus.IO[ADDR_W-1:0];

    always_ff @(posedge SCL) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            addr  <= addrNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        addrNext  = addr;
        errNext   = 1'b0;
        rdNext    = 1'b0;
        wrEn      = 1'b0;
        wrAddr    = addr;
        wrData    = 8'hFF;
        chipErase = 1'b0;
        if (state == BUSY) begin
            // Bytes arriving while busy are dropped; only the error pulse records them.
            cntNext   = cnt - CNT_W'(1);
            stateNext = (cnt == CNT_W'(1)) ? IDLE : BUSY;
            errNext   = bus.IOValid;
        end else if (bus.IOValid) begin
            case (state)
                IDLE: begin
                    stateNext = (bus.IO == 8'hAA) ? UNLK : IDLE;
                    errNext   = bus.IO != 8'hAA && bus.IO != 8'h00;
                end
                UNLK: begin
                    stateNext = (bus.IO == 8'h55) ? CMD : IDLE;
                    errNext   = bus.IO != 8'h55 && bus.IO != 8'h00;
                end
                CMD: begin
                    stateNext = IDLE;
                    case (bus.IO)
                        8'hB0: stateNext = PADDR;
                        8'hC0: stateNext = RADDR;
                        8'hD0: stateNext = EADDR;
                        8'hE0: begin
                            chipErase = 1'b1;
                            cntNext   = CNT_W'(CHIP_CYC);
                            stateNext = BUSY;
                        end
                        8'h00: stateNext = IDLE;
                        default: errNext = 1'b1;
                    endcase
                end
                PADDR: begin
                    addrNext  = ioAddr;
                    stateNext = PDATA;
                end
                PDATA: begin
                    // Programming can only clear bits, so the new value is ANDed into the old one.
                    wrEn      = 1'b1;
                    wrData    = mem[addr] & bus.IO;
                    cntNext   = CNT_W'(PROG_CYC);
                    stateNext = BUSY;
                end
                RADDR: begin
                    rdNext    = 1'b1;
                    addrNext  = ioAddr;
                    stateNext = IDLE;
                end
                EADDR: begin
                    wrEn      = 1'b1;
                    wrAddr    = ioAddr;
                    addrNext  = ioAddr;
                    cntNext   = CNT_W'(ERASE_CYC);
                    stateNext = BUSY;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge SCL) begin
        if (Reset || chipErase) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
        end else if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge SCL) begin
        if (Reset) begin
            rdData  <= 8'h00;
            rdValid <= 1'b0;
            error   <= 1'b0;
        end else begin
            rdData  <= rdNext ? mem[ioAddr] : rdData;
            rdValid <= rdNext;
            error   <= errNext;
        end
    end

    assign bus.RdData  = rdData;
    assign bus.RdValid = rdValid;
    assign bus.Error   = error;
    assign bus.Busy    = state == BUSY;
endmodule

// File: tb/tb_flash_cmd_responder.sv
// tb_flash_cmd_responder: directed plus random command transactions checked against a transaction-level array model.
module tb_flash_cmd_responder;
    localparam int AW = 4, PC = 4, EC = 8, CC = 16, DRAIN = CC + 3;

    logic SCL = 1'b0;
    logic Reset;
    flash_cmd_responder_if bus ();

    flash_cmd_responder #(.ADDR_W(AW), .PROG_CYC(PC), .ERASE_CYC(EC), .CHIP_CYC(CC)) dut (
        .SCL(SCL),
        .Reset(Reset),
        .bus(bus.slave)
    );

    always #5 SCL = ~SCL;

    int total = 0, bad = 0;
    logic [7:0] model [16];
    logic [7:0] lastRd;
    logic [7:0] seq [$];
    int errCnt, rdCnt, busyEarly, obsIdx;
    logic [7:0] rdSeen;
    logic [31:0] busyVec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] b, input logic r);
        bus.IO = b;
        bus.IOValid = v;
        Reset = r;
        @(posedge SCL);
        #1;
        if (bus.Error) errCnt++;
        if (bus.RdValid) begin
            rdCnt++;
            rdSeen = bus.RdData;
        end
        if (obsIdx < 0 && bus.Busy) busyEarly++;
        if (obsIdx >= 0 && obsIdx < 32) busyVec[obsIdx] = bus.Busy;
        if (obsIdx >= 0) obsIdx++;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) model[i] = 8'hFF;
        lastRd = 8'h00;
    endtask

    // Sends seq with random idle gaps, then watches DRAIN cycles; busy window is observed from the last byte on.
    task automatic runTxn(input string tag, input int expErr, input int expBusy, input int rdExp, input int intrudeAt);
        errCnt = 0; rdCnt = 0; busyEarly = 0; busyVec = '0; obsIdx = -1;
        foreach (seq[i]) begin
            repeat ($urandom_range(0, 2)) tick(1'b0, 8'($urandom), 1'b0);
            if (i == seq.size() - 1) obsIdx = 0;
            tick(1'b1, seq[i], 1'b0);
        end
        for (int t = 1; t <= DRAIN; t++) tick(t == intrudeAt, 8'($urandom), 1'b0);
        check({tag, ".err"}, 32'(errCnt), 32'(expErr + (intrudeAt > 0 ? 1 : 0)));
        check({tag, ".busy"}, busyVec, (32'd1 << expBusy) - 32'd1);
        check({tag, ".busyEarly"}, 32'(busyEarly), 32'd0);
        check({tag, ".rdCnt"}, 32'(rdCnt), (rdExp >= 0) ? 32'd1 : 32'd0);
        if (rdExp >= 0) check({tag, ".rdData"}, 32'(rdSeen), 32'(rdExp));
        check({tag, ".rdHold"}, 32'(bus.RdData), 32'(lastRd));
    endtask

    function automatic logic [7:0] addrByte(input int a);
        logic [3:0] hi = 4'($urandom);
        return {hi, 4'(a)};
    endfunction

    task automatic doProg(input int a, input logic [7:0] d, input bit intr);
        seq = '{8'hAA, 8'h55, 8'hB0, addrByte(a), d};
        model[a] = model[a] & d;
        runTxn("prog", 0, PC, -1, intr ? int'($urandom_range(1, PC)) : 0);
    endtask

    task automatic doRead(input int a);
        seq = '{8'hAA, 8'h55, 8'hC0, addrByte(a)};
        lastRd = model[a];
        runTxn("read", 0, 0, int'(model[a]), 0);
    endtask

    task automatic doErase(input int a, input bit intr);
        seq = '{8'hAA, 8'h55, 8'hD0, addrByte(a)};
        model[a] = 8'hFF;
        runTxn("erase", 0, EC, -1, intr ? int'($urandom_range(1, EC)) : 0);
    endtask

    task automatic doChip(input bit intr);
        seq = '{8'hAA, 8'h55, 8'hE0};
        for (int i = 0; i < 16; i++) model[i] = 8'hFF;
        runTxn("chip", 0, CC, -1, intr ? int'($urandom_range(1, CC)) : 0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, ".Busy"}, 32'(bus.Busy), 32'd0);
        check({tag, ".Error"}, 32'(bus.Error), 32'd0);
        check({tag, ".RdValid"}, 32'(bus.RdValid), 32'd0);
        check({tag, ".RdData"}, 32'(bus.RdData), 32'h00);
    endtask

    function automatic logic [7:0] pickNot(input logic [7:0] a, input logic [7:0] b, input bit cmdSet);
        logic [7:0] x;
        do x = 8'($urandom);
        while (x == a || x == b || (cmdSet && (x == 8'hB0 || x == 8'hC0 || x == 8'hD0 || x == 8'hE0)));
        return x;
    endfunction

    initial begin
        bus.IO = 8'h00; bus.IOValid = 1'b0; Reset = 1'b1;
        obsIdx = -1; errCnt = 0; rdCnt = 0;
        modelReset();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        checkIdleOutputs("reset");

        doRead(3);
        doProg(5, 8'h3C, 0);
        doRead(5);
        doProg(5, 8'hF0, 0);
        doRead(5);
        doProg(6, 8'h5A, 0);
        doErase(5, 0);
        doRead(5);
        doRead(6);
        doProg(1, 8'h00, 0);
        doProg(2, 8'h00, 0);
        doChip(0);
        doRead(1);
        doRead(2);

        seq = '{8'hAA, 8'h56};         runTxn("badUnlk", 1, 0, -1, 0);
        seq = '{8'hAA, 8'h55, 8'h77};  runTxn("badCmd", 1, 0, -1, 0);
        seq = '{8'hAA, 8'h00};         runTxn("abortUnlk", 0, 0, -1, 0);
        seq = '{8'h00};                runTxn("abortIdle", 0, 0, -1, 0);
        seq = '{8'hAA, 8'h55, 8'h00};  runTxn("abortCmd", 0, 0, -1, 0);
        doProg(7, 8'hA5, 1);
        doErase(7, 1);
        doChip(1);

        doProg(9, 8'h12, 0);
        obsIdx = -1;
        foreach (seq[i]) if (i < 4) tick(1'b1, seq[i], 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        modelReset();
        checkIdleOutputs("rstPdata");
        tick(1'b0, 8'h00, 1'b0);
        check("rstPdata.quiet", 32'(bus.Error | bus.Busy | bus.RdValid), 32'd0);
        for (int a = 0; a < 16; a++) doRead(a);

        doProg(4, 8'h0F, 0);
        seq = '{8'hAA, 8'h55, 8'hB0, 8'h03, 8'h81};
        obsIdx = -1;
        foreach (seq[i]) tick(1'b1, seq[i], 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check("midBusy.Busy", 32'(bus.Busy), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        modelReset();
        checkIdleOutputs("rstBusy");
        for (int a = 0; a < 16; a++) doRead(a);
        doProg(3, 8'h81, 0);
        doRead(3);

        for (int n = 0; n < 200; n++) begin
            int a = int'($urandom_range(0, 15));
            case ($urandom_range(0, 8))
                0, 1: doProg(a, 8'($urandom), ($urandom_range(0, 3) == 0));
                2, 3: doRead(a);
                4:    doErase(a, ($urandom_range(0, 3) == 0));
                5:    if ($urandom_range(0, 3) == 0) doChip($urandom_range(0, 1) == 1);
                      else doRead(a);
                6: begin
                    case ($urandom_range(0, 2))
                        0: seq = '{8'h00};
                        1: seq = '{8'hAA, 8'h00};
                        default: seq = '{8'hAA, 8'h55, 8'h00};
                    endcase
                    runTxn("abort", 0, 0, -1, 0);
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0: seq = '{pickNot(8'hAA, 8'h00, 0)};
                        1: seq = '{8'hAA, pickNot(8'h55, 8'h00, 0)};
                        default: seq = '{8'hAA, 8'h55, pickNot(8'h00, 8'h00, 1)};
                    endcase
                    runTxn("bad", 1, 0, -1, 0);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flash_cmd_responder.md
Name: flash_cmd_responder

Overview:
Flash-side responder for the command byte stream the controller drives on IO. Decodes the unlock sequence AA,55 followed by a command byte (B0 program, C0 read, D0 byte erase, E0 chip erase, 00 abort). Executes each command against an internal byte array and models busy time. Returns read data to the controller's shift-register input path. Used as the bench/behavioural flash model and as the on-chip responder.

Parameters:
ADDR_W, 4, address bits; array depth = 2**ADDR_W bytes
PROG_CYC, 4, SCL cycles Busy is held after a program
ERASE_CYC, 8, SCL cycles Busy is held after a byte erase
CHIP_CYC, 16, SCL cycles Busy is held after a chip erase

Ports:
SCL  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high
IO  input  8  command/address/data byte from controller
IOValid  input  1  one-cycle strobe: IO holds a valid byte this cycle
RdData  output  8  read-back byte
RdValid  output  1  one-cycle strobe: RdData valid
Busy  output  1  high while a program or erase executes
Error  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (sampled at rising SCL): state IDLE; RdData=8'h00, RdValid=0, Busy=0, Error=0; busy counter=0; every array byte=8'hFF. Reset overrides everything, including mid-command and mid-busy.
- Only cycles with IOValid=1 advance the decoder. IOValid=0 holds the state. There is no timeout.
- States and transitions on an IOValid byte:
  - IDLE: AA -> UNLK; 00 -> IDLE, no error; other -> IDLE with Error.
  - UNLK: 55 -> CMD; 00 -> IDLE; other -> IDLE with Error.
  - CMD: B0 -> PADDR; C0 -> RADDR; D0 -> EADDR; E0 -> start chip erase, go to BUSY; 00 -> IDLE; other -> IDLE with Error.
  - PADDR: latch IO[ADDR_W-1:0] -> PDATA. Upper address bits are ignored.
  - PDATA: mem[addr] <= mem[addr] & IO (program clears bits only; it cannot set a 0 to 1); load busy counter=PROG_CYC; go to BUSY.
  - RADDR: go to IDLE; on the next cycle RdData=mem[addr] and RdValid=1 for exactly one cycle. Read costs no busy time.
  - EADDR: mem[addr] <= 8'hFF; load busy counter=ERASE_CYC; go to BUSY.
- In PADDR, PDATA, RADDR and EADDR the byte is taken as address/data. 00 is not treated as abort in these states.
- Chip erase: all bytes become 8'hFF in the cycle E0 is accepted; counter=CHIP_CYC.
- BUSY:
  - Busy=1 from the cycle after the triggering byte.
  - Counter decrements each cycle; at 1 -> IDLE, and Busy=0 the following cycle.
  - Busy is high for exactly N cycles.
  - Any IOValid byte during BUSY is discarded and pulses Error. The count is unaffected.
- RdData holds its last value between reads. RdValid and Error are never high for more than one cycle per event.
- Error and RdValid are registered: they assert the cycle after the offending or triggering byte.

Test Plan:
- Reset, then read addr 3 (AA,55,C0,03) -> RdData=FF, RdValid single pulse, Error never set.
- Program AA,55,B0,05,3C -> Busy high exactly 4 cycles; then read addr 5 -> 3C. Program again with F0 -> read gives 30 (AND semantics).
- Byte erase AA,55,D0,05 after the previous case -> Busy 8 cycles; read addr 5 -> FF; addr 6 keeps its prior value.
- Program addrs 1 and 2 with 00, then chip erase AA,55,E0 -> Busy 16 cycles; reads of addrs 1 and 2 -> FF.
- Bad sequences:
  - AA,56 -> Error pulse, return to IDLE.
  - AA,55,77 -> Error pulse.
  - AA,00 -> IDLE, no Error.
  - Byte sent during BUSY -> Error pulse, busy length unchanged.
- Reset asserted mid-program (during PDATA wait) and mid-BUSY -> outputs at reset values next cycle; array all FF; a subsequent full program succeeds.
